// File: rtl/universal_shift_reg.sv
// ----------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//    Parametrised universal shift register for the multiplier/divider
//    datapaths. Supports hold, parallel load, logical/arithmetic right shift,
//    left shift, rotate right/left and clear as single-cycle operations, plus
//    a counted multi-position shift sequence with a busy/done handshake so
//    the control unit can issue one command instead of stepping each shift.
//
// Configuration macro:
//    USR_ROTATE_EN - when defined, opcodes 101 (ROR) and 110 (ROL) rotate in
//                    both single-step and counted modes. When undefined they
//                    behave as HOLD and cannot launch a counted sequence.
//
// Parameters:
//    BITS - register width (>= 2)
//    CW   - width of the shift-amount field (2**CW > BITS)
//
// Ports:
//    clk          in   clock, all state updates on rising edge
//    rst          in   synchronous reset, active low
//    i_en         in   enable; 0 freezes register and sequencer
//    i_op         in   operation code
//    i_start      in   launch counted shift sequence using i_op / i_amt
//    i_amt        in   number of positions for a counted sequence
//    i_din_r      in   serial input entering MSB on right shifts
//    i_din_l      in   serial input entering LSB on left shifts
//    i_dp         in   parallel load data
//    o_out_ser_r  out  register bit 0
//    o_out_ser_l  out  register bit BITS-1
//    o_out_par    out  register contents
//    o_busy       out  counted sequence in progress
//    o_done       out  one-cycle pulse at sequence completion
// ----------------------------------------------------------------------------
module universal_shift_reg #(
   parameter int BITS = 8,
   parameter int CW   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic [2:0]      i_op,
   input  logic            i_start,
   input  logic [CW-1:0]   i_amt,
   input  logic            i_din_r,
   input  logic            i_din_l,
   input  logic [BITS-1:0] i_dp,
   output logic            o_out_ser_r,
   output logic            o_out_ser_l,
   output logic [BITS-1:0] o_out_par,
   output logic            o_busy,
   output logic            o_done
);

   // Operation codes
   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SRL  = 3'b010;
   localparam logic [2:0] OP_SRA  = 3'b011;
   localparam logic [2:0] OP_SL   = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ROL  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   // Sequencer states
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   // -------------------------------------------------------------------------
   // One step of an operation applied to the current register value.
   // Rotates collapse to HOLD when the rotate feature is not built in.
   // -------------------------------------------------------------------------
   function automatic logic [BITS-1:0] f_step(
      input logic [2:0]      op,
      input logic [BITS-1:0] cur,
      input logic [BITS-1:0] dp,
      input logic            dr,
      input logic            dl
   );
      logic [BITS-1:0] res;
      res = cur;
      case (op)
         OP_HOLD: res = cur;
         OP_LOAD: res = dp;
         OP_SRL:  res = {dr, cur[BITS-1:1]};
         OP_SRA:  res = {cur[BITS-1], cur[BITS-1:1]};
         OP_SL:   res = {cur[BITS-2:0], dl};
`ifdef USR_ROTATE_EN
         OP_ROR:  res = {cur[0], cur[BITS-1:1]};
         OP_ROL:  res = {cur[BITS-2:0], cur[BITS-1]};
`else
         OP_ROR:  res = cur;
         OP_ROL:  res = cur;
`endif
         OP_CLR:  res = {BITS{1'b0}};
         default: res = cur;
      endcase
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // True for opcodes that may launch a counted sequence.
   // -------------------------------------------------------------------------
   function automatic logic f_is_seq_op(input logic [2:0] op);
      logic res;
      res = 1'b0;
      case (op)
         OP_SRL:  res = 1'b1;
         OP_SRA:  res = 1'b1;
         OP_SL:   res = 1'b1;
`ifdef USR_ROTATE_EN
         OP_ROR:  res = 1'b1;
         OP_ROL:  res = 1'b1;
`endif
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [1:0]      r_state;
   logic [BITS-1:0] r_reg;
   logic [2:0]      r_op_q;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;

   logic [1:0]      w_state_nxt;
   logic [BITS-1:0] w_reg_nxt;
   logic [2:0]      w_op_q_nxt;
   logic [CW-1:0]   w_cnt_nxt;

   // Next-state logic for the sequencer and the register contents.
   always_comb begin
      w_state_nxt = r_state;
      w_reg_nxt   = r_reg;
      w_op_q_nxt  = r_op_q;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (i_en) begin
               if (i_start && f_is_seq_op(i_op)) begin
                  // Latch the command only; the first shift happens next cycle.
                  w_op_q_nxt = i_op;
                  w_cnt_nxt  = i_amt;
                  if (i_amt != CNT_ZERO) begin
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_DONE;
                  end
               end else begin
                  // Non-shift start requests fall through as an ordinary step.
                  w_reg_nxt = f_step(i_op, r_reg, i_dp, i_din_r, i_din_l);
               end
            end else begin
               w_reg_nxt = r_reg;
            end
         end
         ST_RUN: begin
            if (i_en) begin
               // Serial inputs are taken live on every step of the sequence.
               w_reg_nxt = f_step(r_op_q, r_reg, i_dp, i_din_r, i_din_l);
               w_cnt_nxt = r_cnt - CNT_ONE;
               // A zero count here is unreachable; it is treated as the last
               // step so a corrupted counter cannot wrap into a long run.
               if ((r_cnt == CNT_ONE) || (r_cnt == CNT_ZERO)) begin
                  w_cnt_nxt   = CNT_ZERO;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            // Leave DONE unconditionally so done is always a single pulse.
            w_state_nxt = ST_IDLE;
         end
         default: begin
            // Illegal encoding: recover to IDLE with a clean counter.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_reg   <= {BITS{1'b0}};
         r_op_q  <= OP_HOLD;
         r_cnt   <= CNT_ZERO;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_reg   <= w_reg_nxt;
         r_op_q  <= w_op_q_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   assign o_out_par   = r_reg;
   assign o_out_ser_r = r_reg[0];
   assign o_out_ser_l = r_reg[BITS-1];
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

   localparam int BITS = 8;
   localparam int CW   = 4;
`ifdef USR_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en = 1'b0;
   logic [2:0]      op = 3'd0;
   logic            start = 1'b0;
   logic [CW-1:0]   amt = 4'd0;
   logic            din_r = 1'b0;
   logic            din_l = 1'b0;
   logic [BITS-1:0] dp = 8'h00;
   logic            ser_r, ser_l, busy, done;
   logic [BITS-1:0] par;

   int total = 0;
   int bad = 0;

   // reference model state
   logic [7:0] m_par = 8'h00;
   int         m_left = 0;
   bit         m_done = 1'b0;
   logic [2:0] m_op = 3'd0;

   universal_shift_reg #(.BITS(BITS), .CW(CW)) dut (
      .clk(clk), .rst(rst), .i_en(en), .i_op(op), .i_start(start),
      .i_amt(amt), .i_din_r(din_r), .i_din_l(din_l), .i_dp(dp),
      .o_out_ser_r(ser_r), .o_out_ser_l(ser_l), .o_out_par(par),
      .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      en = 1'b1; start = 1'b0; op = 3'd1; dp = v;
      cyc();
      op = 3'd0;
   endtask

   // Arithmetic description of one operation on an 8-bit value.
   function automatic logic [7:0] ref_step(input logic [2:0] o, input logic [7:0] v,
                                           input logic [7:0] d, input logic dr, input logic dl);
      int u;
      u = int'(v);
      case (o)
         3'd0: return v;
         3'd1: return d;
         3'd2: return 8'((u / 2) + (dr ? 128 : 0));
         3'd3: return 8'((u / 2) + ((u >= 128) ? 128 : 0));
         3'd4: return 8'(((u * 2) + (dl ? 1 : 0)) % 256);
         3'd5: return ROT_EN ? 8'((u / 2) + (u % 2) * 128) : v;
         3'd6: return ROT_EN ? 8'(((u * 2) % 256) + (u / 128)) : v;
         default: return 8'h00;
      endcase
   endfunction

   function automatic bit ref_is_shift(input logic [2:0] o);
      return (o == 3'd2) || (o == 3'd3) || (o == 3'd4) ||
             (ROT_EN && ((o == 3'd5) || (o == 3'd6)));
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_clock();
      if (!rst) begin
         m_par = 8'h00; m_left = 0; m_done = 1'b0; m_op = 3'd0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         if (en) begin
            m_par = ref_step(m_op, m_par, dp, din_r, din_l);
            m_left--;
            if (m_left == 0) m_done = 1'b1;
         end
      end else if (en) begin
         if (start && ref_is_shift(op)) begin
            m_op = op;
            m_left = int'(amt);
            if (amt == 4'd0) m_done = 1'b1;
         end else begin
            m_par = ref_step(op, m_par, dp, din_r, din_l);
         end
      end
   endtask

   task automatic test_reset();
      cyc();
      total++;
      if (par !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL power_on_reset: par=%h busy=%b done=%b, required 00 0 0", par, busy, done);
      end
      rst = 1'b1;
      load(8'hFF);
      op = 3'd2; start = 1'b1; amt = 4'd5; din_r = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      total++;
      if (par !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_after_activity: par=%h busy=%b done=%b, required 00 0 0", par, busy, done);
      end
      total++;
      if (ser_r !== 1'b0 || ser_l !== 1'b0) begin
         bad++;
         $display("FAIL reset_serial: ser_r=%b ser_l=%b, required 0 0", ser_r, ser_l);
      end
      rst = 1'b1; en = 1'b0; din_r = 1'b0;
      cyc();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_resume: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_single_ops();
      load(8'hA5);
      total++;
      if (par !== 8'hA5 || ser_r !== 1'b1 || ser_l !== 1'b1) begin
         bad++;
         $display("FAIL load_a5: par=%h ser_r=%b ser_l=%b, required a5 1 1", par, ser_r, ser_l);
      end
      op = 3'd2; din_r = 1'b0;
      cyc();
      total++;
      if (par !== 8'h52) begin bad++; $display("FAIL srl_din0: par=%h, required 52", par); end
      load(8'h96);
      op = 3'd3; din_r = 1'b0;
      cyc();
      total++;
      if (par !== 8'hCB) begin bad++; $display("FAIL sra: par=%h, required cb", par); end
      load(8'h96);
      op = 3'd4; din_l = 1'b1;
      cyc();
      total++;
      if (par !== 8'h2D) begin bad++; $display("FAIL sl_din1: par=%h, required 2d", par); end
      op = 3'd0; din_l = 1'b0;
      cyc();
      total++;
      if (par !== 8'h2D) begin bad++; $display("FAIL hold: par=%h, required 2d", par); end
      op = 3'd2; din_r = 1'b1;
      cyc();
      total++;
      if (par !== 8'h96) begin bad++; $display("FAIL srl_din1: par=%h, required 96", par); end
      op = 3'd7;
      cyc();
      total++;
      if (par !== 8'h00) begin bad++; $display("FAIL clr: par=%h, required 00", par); end
      en = 1'b0; op = 3'd1; dp = 8'hFF;
      cyc();
      total++;
      if (par !== 8'h00) begin bad++; $display("FAIL stall_load: par=%h, required 00", par); end
      en = 1'b1; op = 3'd0; din_r = 1'b0;
   endtask

   // Load 0xF0, run SRL by 3 with optional stall, scramble op/start/dp meanwhile.
   task automatic test_counted(input int stall_at, input int stall_len, input int exp_busy);
      int nb, nd;
      bit finished;
      logic [7:0] done_par;
      nb = 0; nd = 0; finished = 1'b0; done_par = 8'h00;
      load(8'hF0);
      op = 3'd2; start = 1'b1; amt = 4'd3; din_r = 1'b0;
      cyc();
      total++;
      if (par !== 8'hF0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL counted_start: par=%h busy=%b, required f0 1", par, busy);
      end
      for (int i = 0; i < 20; i++) begin
         if (busy) nb++;
         if (done) begin nd++; done_par = par; end
         if (!busy && !done) begin finished = 1'b1; break; end
         en = !((i >= stall_at) && (i < stall_at + stall_len));
         op = 3'($urandom_range(0, 7));
         start = 1'($urandom_range(0, 1));
         amt = 4'($urandom_range(0, 15));
         dp = 8'($urandom);
         cyc();
      end
      en = 1'b1; op = 3'd0; start = 1'b0;
      total++;
      if (!finished) begin
         bad++;
         $display("FAIL counted_timeout: sequence still active after 20 cycles, required finish");
      end
      total++;
      if (nb != exp_busy) begin
         bad++;
         $display("FAIL counted_busy_len: busy cycles=%0d, required %0d", nb, exp_busy);
      end
      total++;
      if (nd != 1 || done_par !== 8'h1E) begin
         bad++;
         $display("FAIL counted_done: done cycles=%0d par=%h, required 1 1e", nd, done_par);
      end
      total++;
      if (par !== 8'h1E) begin bad++; $display("FAIL counted_result: par=%h, required 1e", par); end
   endtask

   task automatic test_amt_zero();
      load(8'h3C);
      op = 3'd2; start = 1'b1; amt = 4'd0; din_r = 1'b1;
      cyc();
      total++;
      if (busy !== 1'b0 || done !== 1'b1 || par !== 8'h3C) begin
         bad++;
         $display("FAIL amt0_done: busy=%b done=%b par=%h, required 0 1 3c", busy, done, par);
      end
      start = 1'b0; op = 3'd0;
      cyc();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || par !== 8'h3C) begin
         bad++;
         $display("FAIL amt0_after: busy=%b done=%b par=%h, required 0 0 3c", busy, done, par);
      end
      op = 3'd1; start = 1'b1; dp = 8'h77; amt = 4'd4;
      cyc();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || par !== 8'h77) begin
         bad++;
         $display("FAIL start_load: busy=%b done=%b par=%h, required 0 0 77", busy, done, par);
      end
      start = 1'b0; op = 3'd0; din_r = 1'b0;
      cyc();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL start_load_after: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_rotate();
      load(8'h81);
      op = 3'd5;
      cyc();
      total++;
      if (par !== (ROT_EN ? 8'hC0 : 8'h81)) begin
         bad++;
         $display("FAIL ror: par=%h, required %h", par, ROT_EN ? 8'hC0 : 8'h81);
      end
      load(8'h81);
      op = 3'd6;
      cyc();
      total++;
      if (par !== (ROT_EN ? 8'h03 : 8'h81)) begin
         bad++;
         $display("FAIL rol: par=%h, required %h", par, ROT_EN ? 8'h03 : 8'h81);
      end
      load(8'h81);
      op = 3'd5; start = 1'b1; amt = 4'd3;
      cyc();
      start = 1'b0; op = 3'd0;
`ifdef USR_ROTATE_EN
      total++;
      if (busy !== 1'b1 || par !== 8'h81) begin
         bad++;
         $display("FAIL ror_seq_start: busy=%b par=%h, required 1 81", busy, par);
      end
      cyc(); cyc(); cyc();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || par !== 8'h30) begin
         bad++;
         $display("FAIL ror_seq_done: done=%b busy=%b par=%h, required 1 0 30", done, busy, par);
      end
      cyc();
`else
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || par !== 8'h81) begin
         bad++;
         $display("FAIL ror_seq_ignored: busy=%b done=%b par=%h, required 0 0 81", busy, done, par);
      end
      cyc();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL ror_seq_ignored_after: busy=%b done=%b, required 0 0", busy, done);
      end
`endif
   endtask

   task automatic test_reset_mid_seq();
      int seen;
      seen = 0;
      load(8'hAB);
      op = 3'd2; start = 1'b1; amt = 4'd5; din_r = 1'b0;
      cyc();
      start = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      total++;
      if (par !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: par=%h busy=%b done=%b, required 00 0 0", par, busy, done);
      end
      rst = 1'b1; op = 3'd0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (done || busy) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rst_mid_no_done: active cycles=%0d, required 0", seen);
      end
      test_counted(0, 0, 3);
   endtask

   task automatic test_random();
      rst = 1'b0;
      model_clock();
      cyc();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) >= 2);
         en = ($urandom_range(0, 99) < 80);
         start = ($urandom_range(0, 99) < 25);
         op = 3'($urandom_range(0, 7));
         amt = 4'($urandom_range(0, 15));
         dp = 8'($urandom);
         din_r = 1'($urandom_range(0, 1));
         din_l = 1'($urandom_range(0, 1));
         model_clock();
         cyc();
         total++;
         if (par !== m_par || busy !== (m_left > 0) || done !== m_done ||
             ser_r !== m_par[0] || ser_l !== m_par[7]) begin
            bad++;
            $display("FAIL random cycle %0d: par=%h busy=%b done=%b ser_r=%b ser_l=%b, required par=%h busy=%b done=%b",
                     i, par, busy, done, ser_r, ser_l, m_par, (m_left > 0), m_done);
         end
      end
      rst = 1'b1; start = 1'b0; en = 1'b1; op = 3'd0;
   endtask

   initial begin
      test_reset();
      test_single_ops();
      test_counted(0, 0, 3);
      test_counted(1, 2, 5);
      test_amt_zero();
      test_rotate();
      test_reset_mid_seq();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register for the multiplier/divider datapaths, generalising the load/right-shift accumulator register. Adds left shift, arithmetic right shift, rotate, clear, and a counted multi-position shift sequence with busy/done handshake, so the control unit can issue one command instead of stepping every shift. Sits in the datapath under control-unit command; serial outputs at both ends chain to neighbouring registers such as the multiplier Q register.

## Interface
Parameters:
- BITS, 8: register width, ≥ 2.
- CW, 4: width of shift-amount field; 2^CW > BITS required.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  enable; 0 freezes register and sequencer (stall).
- op  in  3  operation code (see Operation).
- start  in  1  launches counted shift sequence using op and amt.
- amt  in  CW  number of positions for counted sequence.
- din_r  in  1  serial input entering MSB on right shifts.
- din_l  in  1  serial input entering LSB on left shifts.
- dp  in  BITS  parallel load data.
- out_ser_r  out  1  state[0].
- out_ser_l  out  1  state[BITS-1].
- out_par  out  BITS  state.
- busy  out  1  counted sequence in progress.
- done  out  1  one-cycle pulse at sequence completion.

## Operation
- Opcodes, one step each: 000 HOLD; 001 LOAD (state←dp); 010 SRL ({din_r, state[BITS-1:1]}); 011 SRA ({state[BITS-1], state[BITS-1:1]}, din_r ignored); 100 SL ({state[BITS-2:0], din_l}); 101 ROR; 110 ROL; 111 CLR (state←0).
- FSM states: IDLE, RUN, DONE.
- IDLE, en=1, start=0: op applied once per cycle.
- IDLE, en=1, start=1, op ∈ {010,011,100,101,110}: op and amt latched into op_q and cnt; no shift that cycle. amt≠0 → RUN; amt=0 → DONE.
- IDLE, start=1 with non-shift op (000,001,111): start ignored; op executes as single step.
- RUN: each cycle with en=1 applies op_q one position and decrements cnt; serial inputs sampled live every cycle. cnt reaching 0 → DONE. en=0: no shift, cnt held.
- DONE: register held regardless of op; done=1; next state IDLE unconditionally (en not required).
- start and op ignored while in RUN or DONE.
- amt > BITS permitted; performs amt single-position steps (e.g. SRL with din_r=0 clears).
- busy=1 in RUN; done=1 in DONE only.

## Timing
- Reset: out_par=0, out_ser_r=0, out_ser_l=0, busy=0, done=0, state IDLE, cnt=0; takes effect at the edge sampling rst=0, also mid-sequence (no done pulse emitted).
- Single-step ops: result visible one cycle after the sampling edge.
- Counted sequence with start sampled at edge k and en held high: shifts at edges k+1…k+amt; busy high between edges k+1 and k+amt; done high for the cycle after edge k+amt; IDLE after edge k+amt+1. Each en=0 cycle in RUN extends busy by one cycle.
- amt=0: busy never asserts; done high for the cycle after edge k.
- Outputs are registered state only; no combinational input→output paths.

## Configuration
- USR_ROTATE_EN defined: opcodes 101/110 rotate as specified, in single-step and counted modes.
- Not defined: 101/110 act as HOLD in IDLE; start with 101/110 is ignored like non-shift ops.

## Test plan
- Reset: rst=0 for one edge after arbitrary activity → out_par=0x00, busy=0, done=0, out_ser_r=0, out_ser_l=0.
- LOAD dp=0xA5 → out_par=0xA5, out_ser_r=1, out_ser_l=1; then SRL din_r=0 → 0x52; SRA on 0x96 → 0xCB; SL din_l=1 on 0x96 → 0x2D.
- Counted: load 0xF0, start SRL amt=3, din_r=0, en=1 → out_par=0x1E, busy high 3 cycles, done one cycle; repeat with en=0 for 2 cycles mid-run → same result, busy 5 cycles; op changes during RUN have no effect.
- amt=0 start → done one cycle after start, busy never high, out_par unchanged; start with op=001 → behaves as LOAD, no busy/done.
- Rotate: ROR on 0x81 → 0xC0, ROL on 0x81 → 0x03 with USR_ROTATE_EN; without macro → 0x81 unchanged, start with op=101 gives no busy/done.
- rst=0 at second shift of amt=5 SRL → next cycle out_par=0, busy=0, done never pulses; new start then runs normally.
